// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic register chain.
package pipe_pkg;

  localparam int MAX_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register slot: loads from its predecessor whenever it is empty
// or the downstream slot can take its word, otherwise holds.
module pipe_stage #(
  parameter int                 DWIDTH  = 32,
  parameter logic [DWIDTH-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              v_in,
  input  logic [DWIDTH-1:0] d_in,
  input  logic              r_out,
  output logic              v_o,
  output logic [DWIDTH-1:0] d_o,
  output logic              r_o
);

  // An empty slot always accepts, which is what collapses bubbles.
  assign r_o = !v_o | r_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_o <= 1'b0;
    end else if (flush_i) begin
      v_o <= 1'b0;
    end else if (r_o) begin
      v_o <= v_in;
    end
  end

  // Data only moves with a valid word, so bubbles never toggle the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_o <= RST_VAL;
    end else if (!flush_i && r_o && v_in) begin
      d_o <= d_in;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH elastic register stages with valid/ready on both ends,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int                 DWIDTH  = 32,
  parameter int                 DEPTH   = 2,
  parameter logic [DWIDTH-1:0]  RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  input  logic [DWIDTH-1:0]             in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [DWIDTH-1:0]             out_data_o,
  input  logic                          out_ready_i,
  input  logic                          flush_i,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int CW = cnt_width(DEPTH);

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(bits[i]);
    end
    return acc;
  endfunction

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  v_prev;
  logic [DEPTH-1:0]  v_nxt;
  logic [DEPTH:0]    r;
  logic [DWIDTH-1:0] d      [DEPTH];
  logic [DWIDTH-1:0] d_prev [DEPTH];
  logic [CW-1:0]     cnt_p0;

  // Ready ripples combinationally from the tail so the chain sustains one word per cycle.
  assign r[DEPTH] = out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_prev[k] = in_valid_i;
      assign d_prev[k] = in_data_i;
    end else begin : g_body
      assign v_prev[k] = v[k-1];
      assign d_prev[k] = d[k-1];
    end

    pipe_stage #(
      .DWIDTH  (DWIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .v_in    (v_prev[k]),
      .d_in    (d_prev[k]),
      .r_out   (r[k+1]),
      .v_o     (v[k]),
      .d_o     (d[k]),
      .r_o     (r[k])
    );
  end

  assign in_ready_o  = r[0] & !flush_i;
  assign out_valid_o = v[DEPTH-1] & !flush_i;
  assign out_data_o  = d[DEPTH-1];

  // Mirror of the stage valid updates, used only to register the occupancy.
  always_comb begin
    v_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!flush_i) begin
        v_nxt[k] = r[k] ? v_prev[k] : v[k];
      end
    end
  end

  // Occupancy stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= popcount(v_nxt);
    end
  end

  assign count_o = cnt_p0;

endmodule
